// File: rtl/decode_operand_stage.sv
// D-stage operand resolver and D/E pipeline register.
// Resolves rs/rt from the register-file read data with E/M/W forwarding,
// raises a combinational stall on Tuse/Tnew hazards, and captures the
// resolved instruction into the E-stage register (bubble on stall/flush).
module decode_operand_stage #(
  parameter int DW = 32,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          D_valid,
  input  logic [31:0]   D_PC,
  input  logic [4:0]    D_rs,
  input  logic [4:0]    D_rt,
  input  logic [TW-1:0] D_rs_tuse,
  input  logic [TW-1:0] D_rt_tuse,
  input  logic [4:0]    D_A3,
  input  logic [TW-1:0] D_tnew,
  input  logic [DW-1:0] D_imm,
  input  logic [DW-1:0] R1,
  input  logic [DW-1:0] R2,
  input  logic [DW-1:0] E_WD,
  input  logic [4:0]    M_A3,
  input  logic [TW-1:0] M_tnew,
  input  logic [DW-1:0] M_WD,
  input  logic [4:0]    W_A3,
  input  logic          W_WE,
  input  logic [DW-1:0] W_WD,
  input  logic          flush,
  output logic          stall,
  output logic [DW-1:0] D_rs_fwd,
  output logic [DW-1:0] D_rt_fwd,
  output logic          E_valid,
  output logic [31:0]   E_PC,
  output logic [4:0]    E_rs,
  output logic [4:0]    E_rt,
  output logic [4:0]    E_A3,
  output logic [TW-1:0] E_tnew,
  output logic [DW-1:0] E_rs_val,
  output logic [DW-1:0] E_rt_val,
  output logic [DW-1:0] E_imm
);

  localparam logic [TW-1:0] TUSE_NONE = TW'(3);

  logic          e_valid_q, e_valid_d;
  logic [31:0]   e_pc_q, e_pc_d;
  logic [4:0]    e_rs_q, e_rs_d;
  logic [4:0]    e_rt_q, e_rt_d;
  logic [4:0]    e_a3_q, e_a3_d;
  logic [TW-1:0] e_tnew_q, e_tnew_d;
  logic [DW-1:0] e_rs_val_q, e_rs_val_d;
  logic [DW-1:0] e_rt_val_q, e_rt_val_d;
  logic [DW-1:0] e_imm_q, e_imm_d;

  logic          stall_rs, stall_rt;

  // Forwarding priority: $zero, then youngest producer (E), M, W, register file.
  // A nonzero source can never match a destination of 0, so no A3!=0 test is needed.
  function automatic logic [DW-1:0] resolve(input logic [4:0] s, input logic [DW-1:0] raw);
    logic [DW-1:0] r;
    if (s == 5'd0)                                        r = '0;
    else if (s == e_a3_q && e_valid_q && e_tnew_q == '0)  r = E_WD;
    else if (s == M_A3 && M_tnew == '0)                   r = M_WD;
    else if (s == W_A3 && W_WE)                           r = W_WD;
    else                                                  r = raw;
    return r;
  endfunction

  // A source stalls when a pending producer cannot deliver by its use time.
  function automatic logic hazard(input logic [4:0] s, input logic [TW-1:0] tuse);
    logic h;
    if (s == 5'd0 || tuse == TUSE_NONE) h = 1'b0;
    else h = (s == e_a3_q && e_valid_q && e_tnew_q > tuse) ||
             (s == M_A3 && M_tnew > tuse);
    return h;
  endfunction

  // Combinational operand resolution and stall generation.
  always_comb begin
    D_rs_fwd = resolve(D_rs, R1);
    D_rt_fwd = resolve(D_rt, R2);
    stall_rs = hazard(D_rs, D_rs_tuse);
    stall_rt = hazard(D_rt, D_rt_tuse);
    stall    = D_valid && (stall_rs || stall_rt);
  end

  // Next E-stage contents: bubble by default, D-stage instruction when advancing.
  always_comb begin
    e_valid_d  = 1'b0;
    e_pc_d     = '0;
    e_rs_d     = '0;
    e_rt_d     = '0;
    e_a3_d     = '0;
    e_tnew_d   = '0;
    e_rs_val_d = '0;
    e_rt_val_d = '0;
    e_imm_d    = '0;
    if (!(flush || stall)) begin
      e_valid_d  = D_valid;
      e_pc_d     = D_PC;
      e_rs_d     = D_rs;
      e_rt_d     = D_rt;
      e_a3_d     = D_A3;
      e_tnew_d   = D_tnew;
      e_rs_val_d = D_rs_fwd;
      e_rt_val_d = D_rt_fwd;
      e_imm_d    = D_imm;
    end
  end

  // D/E pipeline register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_valid_q  <= 1'b0;
      e_pc_q     <= '0;
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_a3_q     <= '0;
      e_tnew_q   <= '0;
      e_rs_val_q <= '0;
      e_rt_val_q <= '0;
      e_imm_q    <= '0;
    end else begin
      e_valid_q  <= e_valid_d;
      e_pc_q     <= e_pc_d;
      e_rs_q     <= e_rs_d;
      e_rt_q     <= e_rt_d;
      e_a3_q     <= e_a3_d;
      e_tnew_q   <= e_tnew_d;
      e_rs_val_q <= e_rs_val_d;
      e_rt_val_q <= e_rt_val_d;
      e_imm_q    <= e_imm_d;
    end
  end

  assign E_valid  = e_valid_q;
  assign E_PC     = e_pc_q;
  assign E_rs     = e_rs_q;
  assign E_rt     = e_rt_q;
  assign E_A3     = e_a3_q;
  assign E_tnew   = e_tnew_q;
  assign E_rs_val = e_rs_val_q;
  assign E_rt_val = e_rt_val_q;
  assign E_imm    = e_imm_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the E-stage register.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [4:0]  D_rs, D_rt, D_A3, M_A3, W_A3;
  logic [1:0]  D_rs_tuse, D_rt_tuse, D_tnew, M_tnew;
  logic [31:0] D_imm, R1, R2, E_WD, M_WD, W_WD;
  logic        W_WE, flush;
  logic        stall;
  logic [31:0] D_rs_fwd, D_rt_fwd;
  logic        E_valid;
  logic [31:0] E_PC;
  logic [4:0]  E_rs, E_rt, E_A3;
  logic [1:0]  E_tnew;
  logic [31:0] E_rs_val, E_rt_val, E_imm;

  int tests = 0;
  int fails = 0;

  decode_operand_stage #(.DW(32), .TW(2)) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_PC(D_PC),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_A3(D_A3), .D_tnew(D_tnew), .D_imm(D_imm), .R1(R1), .R2(R2),
    .E_WD(E_WD), .M_A3(M_A3), .M_tnew(M_tnew), .M_WD(M_WD),
    .W_A3(W_A3), .W_WE(W_WE), .W_WD(W_WD), .flush(flush),
    .stall(stall), .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd),
    .E_valid(E_valid), .E_PC(E_PC), .E_rs(E_rs), .E_rt(E_rt), .E_A3(E_A3),
    .E_tnew(E_tnew), .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .E_imm(E_imm)
  );

  always #5 clk = ~clk;

  // Model of the E-stage register contents.
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs, rt, a3;
    logic [1:0]  tnew;
    logic [31:0] rsv, rtv, imm;
  } e_t;

  e_t m = '0;

  function automatic e_t dut_e();
    return {E_valid, E_PC, E_rs, E_rt, E_A3, E_tnew, E_rs_val, E_rt_val, E_imm};
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] s, input logic [31:0] raw);
    if (s == 0) return 32'd0;
    if (m.v && s == m.a3 && m.tnew == 0) return E_WD;
    if (s == M_A3 && M_tnew == 0) return M_WD;
    if (s == W_A3 && W_WE) return W_WD;
    return raw;
  endfunction

  function automatic logic ref_hz(input logic [4:0] s, input logic [1:0] tuse);
    if (s == 0 || tuse == 2'd3) return 1'b0;
    return (m.v && s == m.a3 && m.tnew > tuse) || (s == M_A3 && M_tnew > tuse);
  endfunction

  function automatic logic ref_stall();
    return D_valid && (ref_hz(D_rs, D_rs_tuse) || ref_hz(D_rt, D_rt_tuse));
  endfunction

  // Advance one clock; the model takes its next value from the inputs held across the edge.
  task automatic tick();
    e_t nx;
    if (!reset || flush || ref_stall()) nx = '0;
    else nx = {D_valid, D_PC, D_rs, D_rt, D_A3, D_tnew,
               ref_fwd(D_rs, R1), ref_fwd(D_rt, R2), D_imm};
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic quiet();
    reset = 1; D_valid = 0; D_PC = 0; D_rs = 0; D_rt = 0;
    D_rs_tuse = 3; D_rt_tuse = 3; D_A3 = 0; D_tnew = 0; D_imm = 0;
    R1 = 0; R2 = 0; E_WD = 0; M_A3 = 0; M_tnew = 0; M_WD = 0;
    W_A3 = 0; W_WE = 0; W_WD = 0; flush = 0;
  endtask

  task automatic randomize_inputs();
    D_valid = 1'($urandom); D_PC = $urandom;
    D_rs = 5'($urandom_range(0, 7)); D_rt = 5'($urandom_range(0, 7));
    D_rs_tuse = 2'($urandom); D_rt_tuse = 2'($urandom);
    D_A3 = 5'($urandom_range(0, 7)); D_tnew = 2'($urandom); D_imm = $urandom;
    R1 = $urandom; R2 = $urandom; E_WD = $urandom;
    M_A3 = 5'($urandom_range(0, 7)); M_tnew = 2'($urandom); M_WD = $urandom;
    W_A3 = 5'($urandom_range(0, 7)); W_WE = 1'($urandom); W_WD = $urandom;
    flush = ($urandom_range(0, 9) == 0);
  endtask

  // Load one non-hazarding instruction into E with the given destination/Tnew.
  task automatic load_e(input logic [4:0] a3, input logic [1:0] tn);
    quiet(); D_valid = 1; D_A3 = a3; D_tnew = tn; D_PC = 32'h100;
    tick();
  endtask

  task automatic test_reset();
    randomize_inputs(); reset = 0; tick();
    randomize_inputs(); reset = 0; tick();
    tests++;
    if (dut_e() !== '0) begin
      fails++; $display("FAIL reset: E regs got %h, expected 0", dut_e());
    end
    tests++;
    if (E_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b, expected 0", E_valid);
    end
  endtask

  task automatic test_w_forward();
    quiet(); tick();
    W_A3 = 5; W_WE = 1; W_WD = 32'h1234; D_valid = 1; D_rs = 5; R1 = 32'hdead;
    #1;
    tests++;
    if (D_rs_fwd !== 32'h1234) begin
      fails++; $display("FAIL w_fwd: D_rs_fwd=%h expected 00001234", D_rs_fwd);
    end
    tick();
    tests++;
    if (E_rs_val !== 32'h1234 || E_valid !== 1'b1) begin
      fails++; $display("FAIL w_fwd_reg: E_rs_val=%h E_valid=%b expected 00001234/1", E_rs_val, E_valid);
    end
  endtask

  task automatic test_priority();
    load_e(5, 0);
    E_WD = 32'hA; M_A3 = 5; M_tnew = 0; M_WD = 32'hB;
    W_A3 = 5; W_WE = 1; W_WD = 32'hC; D_rs = 5; D_rt = 5; R1 = 32'h1; R2 = 32'h2;
    #1;
    tests++;
    if (D_rs_fwd !== 32'hA || D_rt_fwd !== 32'hA) begin
      fails++; $display("FAIL priority: rs=%h rt=%h expected 0000000a", D_rs_fwd, D_rt_fwd);
    end
    M_tnew = 1; #1;
    tests++;
    if (D_rs_fwd !== 32'hA) begin
      fails++; $display("FAIL priority_e: rs=%h expected 0000000a", D_rs_fwd);
    end
  endtask

  task automatic test_load_use();
    load_e(8, 2);
    D_valid = 1; D_rs = 8; D_rs_tuse = 1; D_rt = 0; D_A3 = 9; D_tnew = 1;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL load_use_stall: stall=%b expected 1", stall);
    end
    tick();
    tests++;
    if (E_valid !== 1'b0 || E_A3 !== 5'd0) begin
      fails++; $display("FAIL load_use_bubble: E_valid=%b E_A3=%0d expected 0/0", E_valid, E_A3);
    end
    M_A3 = 8; M_tnew = 1; #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL load_use_release: stall=%b expected 0", stall);
    end
    tick();
    tests++;
    if (E_valid !== 1'b1 || E_rs !== 5'd8 || E_A3 !== 5'd9) begin
      fails++; $display("FAIL load_use_enter: E_valid=%b E_rs=%0d E_A3=%0d expected 1/8/9", E_valid, E_rs, E_A3);
    end
  endtask

  task automatic test_zero();
    load_e(0, 2);
    D_valid = 1; D_rs = 0; D_rs_tuse = 0; R1 = 32'hffffffff; E_WD = 32'h55;
    #1;
    tests++;
    if (stall !== 1'b0 || D_rs_fwd !== 32'd0) begin
      fails++; $display("FAIL zero: stall=%b D_rs_fwd=%h expected 0/00000000", stall, D_rs_fwd);
    end
  endtask

  task automatic test_flush();
    quiet(); D_valid = 1; D_A3 = 3; D_tnew = 2; flush = 1;
    tick();
    tests++;
    if (E_valid !== 1'b0 || E_A3 !== 5'd0) begin
      fails++; $display("FAIL flush: E_valid=%b E_A3=%0d expected 0/0", E_valid, E_A3);
    end
    flush = 0; D_rs = 3; D_rs_tuse = 0; D_A3 = 4; #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL flush_nohazard: stall=%b expected 0", stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 39) != 0);
      #1;
      if (reset) begin
        tests++;
        if (stall !== ref_stall()) begin
          fails++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall, ref_stall());
        end
      end
      tests++;
      if (D_rs_fwd !== ref_fwd(D_rs, R1) || D_rt_fwd !== ref_fwd(D_rt, R2)) begin
        fails++; $display("FAIL rand_fwd[%0d]: got %h/%h expected %h/%h", i,
                          D_rs_fwd, D_rt_fwd, ref_fwd(D_rs, R1), ref_fwd(D_rt, R2));
      end
      tick();
      tests++;
      if (dut_e() !== m) begin
        fails++; $display("FAIL rand_ereg[%0d]: got %h expected %h", i, dut_e(), m);
      end
    end
  endtask

  initial begin
    quiet();
    #2;
    test_reset();
    test_w_forward();
    test_priority();
    test_load_use();
    test_zero();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
